oled_pixel_streamer: RTL and testbench
======================================

# oled_pixel_streamer

Scans the 96x64 OLED frame pixel by pixel, drives the x/y coordinates into a registered pixel renderer (the miss/score animation blocks), and captures the 16-bit RGB565 pixel that renderer returns. Each captured pixel is shifted out MSB-first on an SPI-style serial link to the display. It is the consumer end of the renderer's coordinate-in/pixel-out interface. It sits between the animation renderers and the OLED pins; display init is handled elsewhere.

## Interface
- WIDTH, 96, pixels per row
- HEIGHT, 64, rows per frame
- XW, 7, width of x output
- YW, 6, width of y output
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; sampled only in IDLE, begins one frame
- oled_data  in  16  RGB565 pixel from renderer; valid 1 cycle after x/y change
- x  out  XW  column currently requested from renderer
- y  out  YW  row currently requested from renderer
- busy  out  1  high from first FETCH cycle through DONE
- frame_done  out  1  one-cycle pulse at end of frame
- sclk  out  1  serial clock, idles low (SPI mode 0)
- mosi  out  1  serial data, MSB first
- cs_n  out  1  chip select, low for whole frame
- dc  out  1  data/command; held 1 (pixel data)

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 at an edge -> next cycle FETCH, x=0, y=0, cs_n=0, busy=1.
- FETCH, 2 cycles:
  - x/y stable.
  - On the edge ending the 2nd cycle, load oled_data into a 16-bit shift register and a 4-bit bit counter=15; go SHIFT.
- SHIFT, per bit:
  - mosi=current MSB; sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - On the edge ending the high phase: shift left and decrement the bit counter; sclk returns to 0.
  - After bit 0's high phase:
    - If x=WIDTH-1 and y=HEIGHT-1 -> DONE.
    - Else if x=WIDTH-1 -> x=0, y=y+1, FETCH.
    - Else x=x+1, FETCH.
- DONE, 1 cycle: cs_n=1, sclk=0, frame_done=1, busy=1; then IDLE with busy=0.
- start is ignored outside IDLE. If start is held high, a new frame begins after exactly one IDLE cycle.
- x/y only change on FETCH entry; they never exceed WIDTH-1/HEIGHT-1. In IDLE they hold their last value (0 after reset).
- Half-period counter: ceil(log2(CLK_DIV)) bits minimum; counts 0..CLK_DIV-1 and wraps.

## Timing
- Reset values: x=0, y=0, busy=0, frame_done=0, sclk=0, mosi=0, cs_n=1, dc=1; state IDLE, counters 0.
- Reset asserted mid-frame aborts immediately, with no completion pulse:
  - all outputs take reset values asynchronously;
  - cs_n rises without frame_done.
- Per pixel: 2 + 32*CLK_DIV cycles. Default is 130.
- Frame, start edge to frame_done: 1 + WIDTH*HEIGHT*(2+32*CLK_DIV) cycles, then 1 IDLE cycle.
- mosi changes only while sclk=0: at SHIFT entry and on falling-edge transitions. It is stable for the whole sclk high phase.
- Renderer latency budget: oled_data is sampled 2 cycles after x/y change, covering the renderer's 1-cycle registered output.

## Test plan
- Reset and idle:
  - Stimulus: reset pulse, start=0 for 100 cycles.
  - Required: cs_n=1, sclk=0, busy=0, x=y=0, frame_done never pulses.
- Single pixel word, WIDTH=2, HEIGHT=1, CLK_DIV=1; constant oled_data=16'hA5C3; one start pulse.
  - mosi sampled on sclk rising edges gives 1010010111000011 twice.
  - frame_done pulses at cycle 1+2*34=69 after the start edge.
  - cs_n is low for the whole transfer.
- Scan order, WIDTH=4, HEIGHT=2, CLK_DIV=1; oled_data={x,y} zero-extended, from a 1-cycle registered model.
  - Received words are 0x0000, 0x0040... matching raster order x-fastest: (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1).
  - x wraps 3->0 while y increments.
- SCLK shape, CLK_DIV=4:
  - Each sclk low and high phase is exactly 4 cycles; 16 rising edges per pixel.
  - mosi never toggles while sclk=1.
- Back-to-back frames, start held high with small params:
  - Exactly one cycle of busy=0 and cs_n=1 between frames.
  - frame_done is exactly one cycle per frame.
  - start pulses while busy cause no restart.
- Reset mid-frame, asserted during SHIFT of pixel 3:
  - Outputs go to reset values within the same cycle; no frame_done.
  - A following start begins again at x=0, y=0.

Source files
------------

// File: rtl/oled_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : oled_pixel_streamer
//  Purpose  : Raster-scans a WIDTH x HEIGHT OLED frame. For each pixel it
//             presents x/y to a registered renderer, captures the returned
//             RGB565 word and shifts it out MSB-first on an SPI mode-0 link.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous, active-high
//             start      - level, sampled only in IDLE, starts one frame
//             oled_data  - RGB565 pixel from renderer (1-cycle latency)
//             x, y       - coordinate currently requested from renderer
//             busy       - high from first FETCH cycle through DONE
//             frame_done - one-cycle pulse at end of frame
//             sclk, mosi - serial clock (idles low) and data, MSB first
//             cs_n       - chip select, low for the whole frame
//             dc         - data/command, tied to 1 (pixel data)
//  Revision : 1.0 - initial release
// ============================================================================
module oled_pixel_streamer #(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 64,
    parameter int XW      = 7,
    parameter int YW      = 6,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   oled_data,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          busy,
    output logic          frame_done,
    output logic          sclk,
    output logic          mosi,
    output logic          cs_n,
    output logic          dc
);

    localparam int            DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            fetch_q, fetch_d;   // second FETCH cycle marker
    logic [15:0]     shreg_q, shreg_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;
    logic            cs_n_q, cs_n_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            fetch_q  <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fetch_q  <= fetch_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        fetch_d  = fetch_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    fetch_d = 1'b0;
                    cs_n_d  = 1'b0;
                end
            end

            FETCH: begin
                // x/y changed on entry; the renderer's registered output is
                // valid from the second cycle, so capture at its end.
                if (fetch_q) begin
                    fetch_d  = 1'b0;
                    shreg_d  = oled_data;
                    bitcnt_d = 4'd15;
                    div_d    = '0;
                    sclk_d   = 1'b0;
                    state_d  = SHIFT;
                end else begin
                    fetch_d  = 1'b1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance data so mosi only moves
                        // while sclk is low.
                        sclk_d   = 1'b0;
                        shreg_d  = {shreg_q[14:0], 1'b0};
                        bitcnt_d = bitcnt_q - 4'd1;
                        if (bitcnt_q == 4'd0) begin
                            if (x_q == X_LAST) begin
                                if (y_q == Y_LAST) begin
                                    state_d = DONE;
                                    cs_n_d  = 1'b1;
                                end else begin
                                    x_d     = '0;
                                    y_d     = y_q + YW'(1);
                                    state_d = FETCH;
                                end
                            end else begin
                                x_d     = x_q + XW'(1);
                                state_d = FETCH;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x          = x_q;
    assign y          = y_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign sclk       = sclk_q;
    assign mosi       = shreg_q[15];
    assign cs_n       = cs_n_q;
    assign dc         = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_oled_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_pixel_streamer
//  Purpose  : Self-checking bench for oled_pixel_streamer. Three instances
//             with small frame geometries run against a frame-timing model
//             that derives every output from the cycle offset into the frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oled_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  start;
    logic [15:0] od0, od1, od2;
    logic [6:0]  xo0, xo1, xo2;
    logic [5:0]  yo0, yo1, yo2;
    logic [2:0]  busy, fd, sclk, mosi, csn, dc;

    assign od0 = 16'hA5C3;

    oled_pixel_streamer #(.WIDTH(2), .HEIGHT(1), .XW(7), .YW(6), .CLK_DIV(1)) u0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .oled_data(od0),
        .x(xo0), .y(yo0), .busy(busy[0]), .frame_done(fd[0]), .sclk(sclk[0]),
        .mosi(mosi[0]), .cs_n(csn[0]), .dc(dc[0]));

    oled_pixel_streamer #(.WIDTH(4), .HEIGHT(2), .XW(7), .YW(6), .CLK_DIV(1)) u1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .oled_data(od1),
        .x(xo1), .y(yo1), .busy(busy[1]), .frame_done(fd[1]), .sclk(sclk[1]),
        .mosi(mosi[1]), .cs_n(csn[1]), .dc(dc[1]));

    oled_pixel_streamer #(.WIDTH(3), .HEIGHT(2), .XW(7), .YW(6), .CLK_DIV(4)) u2 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .oled_data(od2),
        .x(xo2), .y(yo2), .busy(busy[2]), .frame_done(fd[2]), .sclk(sclk[2]),
        .mosi(mosi[2]), .cs_n(csn[2]), .dc(dc[2]));

    // Renderer stand-ins with one cycle of registered latency
    always @(posedge clk) begin
        od1 <= {3'b000, xo1, yo1};
        od2 <= 16'hF0F0 ^ {3'b000, xo2, yo2};
    end

    function automatic int pw(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 3;
    endfunction
    function automatic int ph(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int pd(input int k);
        return (k == 2) ? 4 : 1;
    endfunction
    function automatic logic [15:0] od_of(input int k);
        return (k == 0) ? od0 : (k == 1) ? od1 : od2;
    endfunction

    // ---------------- frame model: state = cycle offset into the frame ----
    bit          m_act  [3];
    bit          m_done [3];
    int          m_t    [3];
    logic [15:0] m_word [3];
    logic [6:0]  m_xh   [3];
    logic [5:0]  m_yh   [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                m_act[k]  <= 1'b0;
                m_done[k] <= 1'b0;
                m_t[k]    <= 0;
                m_xh[k]   <= '0;
                m_yh[k]   <= '0;
            end else if (m_done[k]) begin
                m_done[k] <= 1'b0;
            end else if (m_act[k]) begin
                if (m_t[k] % (2 + 32 * pd(k)) == 1)
                    m_word[k] <= od_of(k);
                m_t[k] <= m_t[k] + 1;
                if (m_t[k] + 1 == pw(k) * ph(k) * (2 + 32 * pd(k))) begin
                    m_act[k]  <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_xh[k]   <= 7'(pw(k) - 1);
                    m_yh[k]   <= 6'(ph(k) - 1);
                end
            end else if (start[k]) begin
                m_act[k] <= 1'b1;
                m_t[k]   <= 0;
            end
        end
    end

    // {x, y, busy, frame_done, sclk, mosi, cs_n, dc}
    function automatic logic [18:0] act_of(input int k);
        case (k)
            0:       return {xo0, yo0, busy[0], fd[0], sclk[0], mosi[0], csn[0], dc[0]};
            1:       return {xo1, yo1, busy[1], fd[1], sclk[1], mosi[1], csn[1], dc[1]};
            default: return {xo2, yo2, busy[2], fd[2], sclk[2], mosi[2], csn[2], dc[2]};
        endcase
    endfunction

    function automatic logic [18:0] exp_of(input int k);
        int P, p, o, s;
        logic [6:0] ex;
        logic [5:0] ey;
        logic eb, ef, es, em, ec;
        P = 2 + 32 * pd(k);
        if (rst[k]) return {7'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ex = m_xh[k]; ey = m_yh[k];
        eb = 1'b0; ef = 1'b0; es = 1'b0; em = 1'b0; ec = 1'b1;
        if (m_act[k]) begin
            p  = m_t[k] / P;
            o  = m_t[k] % P;
            ex = 7'(p % pw(k));
            ey = 6'(p / pw(k));
            eb = 1'b1;
            ec = 1'b0;
            if (o >= 2) begin
                s  = o - 2;
                es = ((s % (2 * pd(k))) >= pd(k));
                em = m_word[k][15 - s / (2 * pd(k))];
            end
        end else if (m_done[k]) begin
            eb = 1'b1;
            ef = 1'b1;
        end
        return {ex, ey, eb, ef, es, em, ec, 1'b1};
    endfunction

    // ---------------- serial receivers (sample mosi on sclk rise) ---------
    logic [31:0] rx0;
    int          rx0_n;
    always @(posedge sclk[0] or posedge rst[0]) begin
        if (rst[0]) begin
            rx0   <= '0;
            rx0_n <= 0;
        end else begin
            rx0   <= {rx0[30:0], mosi[0]};
            rx0_n <= rx0_n + 1;
        end
    end

    logic [15:0] q1[$];
    logic [15:0] sh1;
    int          n1;
    always @(posedge sclk[1] or posedge rst[1]) begin
        if (rst[1]) begin
            q1.delete();
            sh1 = '0;
            n1  = 0;
        end else begin
            sh1 = {sh1[14:0], mosi[1]};
            n1  = n1 + 1;
            if (n1 % 16 == 0) q1.push_back(sh1);
        end
    end

    // ---------------- checking ----------------------------------------
    int checks   = 0;
    int failures = 0;
    int fd_cnt [3];
    int hi2 = 0, r2 = 0;
    logic p_s2 = 1'b0, p_m2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fd(input int k, input int lim);
        int n = 0;
        while (!fd[k] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("frame_done_seen_u%0d", k), 32'(fd[k]), 32'd1);
    endtask

    int cnt, gap, fd_before;

    initial begin
        rst   = 3'b111;
        start = 3'b000;

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("model_u%0d", k), 32'(act_of(k)), 32'(exp_of(k)));
                    if (fd[k]) fd_cnt[k]++;
                end
                if (p_s2 && sclk[2]) chk("mosi_stable_high_u2", 32'(mosi[2]), 32'(p_m2));
                if (sclk[2]) begin
                    if (!p_s2) r2++;
                    hi2++;
                end else begin
                    if (hi2 != 0) chk("sclk_high_len_u2", hi2, 4);
                    hi2 = 0;
                end
                p_s2 = sclk[2];
                p_m2 = mosi[2];
            end
        join_none

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 3'b000;
        repeat (100) @(negedge clk);
        chk("idle_frame_done_count", fd_cnt[0] + fd_cnt[1] + fd_cnt[2], 0);
        chk("idle_cs_n", 32'(csn), 32'h7);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_x1", 32'(xo1), 32'h0);

        // Single pixel word, 2x1, CLK_DIV=1
        start[0] = 1'b1;
        cnt = 0;
        while (!fd[0] && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start[0] = 1'b0;
        end
        chk("frame_done_cycle_u0", cnt, 69);
        chk("rx_words_u0", rx0, 32'hA5C3A5C3);
        chk("rx_bits_u0", rx0_n, 32);
        @(negedge clk);

        // Scan order, 4x2
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_fd(1, 600);
        chk("scan_word_count", q1.size(), 8);
        for (int i = 0; i < 8 && i < q1.size(); i++)
            chk($sformatf("scan_word_%0d", i), 32'(q1[i]), ((i % 4) << 6) | (i / 4));
        if (q1.size() >= 5) begin
            chk("scan_word_1_literal", 32'(q1[1]), 32'h0040);
            chk("scan_word_4_literal", 32'(q1[4]), 32'h0001);
        end
        @(negedge clk);

        // SCLK shape, CLK_DIV=4, 3x2
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        wait_fd(2, 2000);
        chk("sclk_rises_u2", r2, 96);
        @(negedge clk);

        // Back-to-back frames with start held high
        fd_before = fd_cnt[1];
        start[1] = 1'b1;
        wait_fd(1, 600);
        gap = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy[1]) break;
            gap++;
        end
        chk("b2b_idle_gap", gap, 1);
        repeat (20) @(negedge clk);
        start[1] = 1'b0;
        wait_fd(1, 600);
        repeat (5) @(negedge clk);
        chk("b2b_frame_done_count", fd_cnt[1] - fd_before, 2);
        chk("b2b_busy_after", 32'(busy[1]), 32'h0);

        // Reset during SHIFT of pixel 3
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        cnt = 0;
        while (!(xo1 == 7'd3 && sclk[1]) && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        chk("reached_pixel3_shift", 32'(xo1 == 7'd3 && sclk[1]), 32'h1);
        fd_before = fd_cnt[1];
        #2 rst[1] = 1'b1;
        #1;
        chk("async_reset_outputs",
            32'({xo1, yo1, busy[1], fd[1], sclk[1], mosi[1], csn[1], dc[1]}),
            32'({7'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        chk("abort_no_frame_done", fd_cnt[1] - fd_before, 0);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("restart_xy", 32'({xo1, yo1, busy[1]}), 32'({7'd0, 6'd0, 1'b1}));
        wait_fd(1, 600);
        chk("restart_word_count", q1.size(), 8);
        if (q1.size() == 8) chk("restart_last_word", 32'(q1[7]), 32'h00C1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
